// File: rtl/fftc_pkg.sv
// Shared types and constants for the radix-16 NTT datapath over the
// Goldilocks prime p = 2^64 - 2^32 + 1.
//   P_GOLD : the modulus p.
//   EPS    : 2^32 - 1. This is the value of 2^64 mod p, used as the wrap correction.
//   fe_t   : one 64-bit field element.
//   dw_t   : one 128-bit double-width product.
package fftc_pkg;

  localparam logic [63:0] P_GOLD = 64'hFFFFFFFF00000001;
  localparam logic [63:0] EPS    = 64'h00000000FFFFFFFF;

  typedef logic [63:0]  fe_t;
  typedef logic [127:0] dw_t;

endpackage

// File: rtl/gold_reduce128.sv
// Combinational reduction of a 128-bit product modulo p = 2^64 - 2^32 + 1.
// The result is canonical, in the range [0, p-1].
// The reduction relies on two identities: 2^64 = 2^32 - 1 (mod p) and 2^96 = -1 (mod p).
// Ports:
//   x_i : 128-bit input. Any value up to (2^64-1)^2 is accepted.
//   r_o : x_i mod p, canonical.
module gold_reduce128
  import fftc_pkg::*;
(
  input  dw_t x_i,
  output fe_t r_o
);

  logic [31:0] hh;
  logic [31:0] hl;
  logic [64:0] t0_ext;
  fe_t         t0;
  fe_t         t1;
  logic [64:0] r_ext;
  fe_t         r;

  // NOTE: every variable gets an unconditional value at the top of the block,
  // before any if, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    hh     = x_i[127:96];
    hl     = x_i[95:64];
    t0_ext = {1'b0, x_i[63:0]} - {33'b0, hh};
    t0     = t0_ext[63:0];
    t1     = {hl, 32'b0} - {32'b0, hl};
    r_ext  = 65'b0;
    r      = 64'b0;

    // A borrow means t0 wrapped by +2^64. Subtracting EPS removes that 2^64 mod p.
    // After the wrap, t0 >= 2^64 - 2^32 + 1, which is larger than EPS,
    // so this subtraction cannot borrow again.
    if (t0_ext[64]) t0 = t0 - EPS;

    // t1 = hl * 2^64 mod p = hl * (2^32 - 1). It always fits in 64 bits.
    r_ext = {1'b0, t0} + {1'b0, t1};
    r     = r_ext[63:0];
    // A carry means r dropped 2^64. Adding back 2^64 mod p (EPS) corrects it.
    // A wrapped sum is at most 2^64 - 2^33 + 1, so adding EPS cannot carry again.
    if (r_ext[64]) r = r + EPS;

    if (r >= P_GOLD) r = r - P_GOLD;
  end

  assign r_o = r;

endmodule

// File: rtl/horizontal_tf_modmul.sv
// Horizontal twiddle multiplier for one NTT row.
// It computes out_data = (in_data * tf) mod p, with p = 2^64 - 2^32 + 1.
// The pipeline has 4 stages and accepts one product per enabled cycle.
//   S1: register the operands. tf_bypass forces the twiddle operand to 1.
//   S2: four registered 32x32 partial products.
//   S3: registered 128-bit sum of the partial products.
//   S4: Goldilocks reduction, registered as out_data.
// Ports:
//   clk, rst_n        : clock (rising edge) and async active-low reset.
//   CEN               : active-low enable. When 1, every stage, including the valid bits, holds.
//   in_valid, in_data : input sample from the butterfly.
//   tf, tf_bypass     : twiddle from the ROM; tf_bypass=1 treats the twiddle as 1.
//   in_last           : end-of-group tag. It travels alongside the data.
//   out_valid, out_data, out_last : product, and its tag, LATENCY enabled cycles later.
module horizontal_tf_modmul
  import fftc_pkg::*;
#(
  parameter int P_WIDTH = 64,
  parameter int LATENCY = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               CEN,
  input  logic               in_valid,
  input  logic [P_WIDTH-1:0] in_data,
  input  logic [P_WIDTH-1:0] tf,
  input  logic               tf_bypass,
  input  logic               in_last,
  output logic               out_valid,
  output logic [P_WIDTH-1:0] out_data,
  output logic               out_last
);

  // The reduction is specific to p, and the stage count is fixed by the datapath.
  if (P_WIDTH != 64 || LATENCY != 4) begin : g_bad_param
    $error("horizontal_tf_modmul supports only P_WIDTH=64, LATENCY=4");
  end

  // One valid bit and one last bit per stage. Index LATENCY-1 drives the outputs.
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [LATENCY-1:0] last_q, last_d;

  fe_t a_q, a_d;
  fe_t b_q, b_d;
  fe_t p_ll_q, p_ll_d;
  fe_t p_lh_q, p_lh_d;
  fe_t p_hl_q, p_hl_d;
  fe_t p_hh_q, p_hh_d;
  dw_t x_q, x_d;
  fe_t out_q, out_d;
  fe_t red;

  logic en;
  assign en = ~CEN;

  gold_reduce128 u_reduce (
    .x_i (x_q),
    .r_o (red)
  );

  always_comb begin
    vld_d  = {vld_q[LATENCY-2:0], in_valid};
    last_d = {last_q[LATENCY-2:0], in_last};

    a_d = in_data;
    b_d = tf_bypass ? 64'd1 : tf;

    p_ll_d = {32'b0, a_q[31:0]}  * {32'b0, b_q[31:0]};
    p_lh_d = {32'b0, a_q[31:0]}  * {32'b0, b_q[63:32]};
    p_hl_d = {32'b0, a_q[63:32]} * {32'b0, b_q[31:0]};
    p_hh_d = {32'b0, a_q[63:32]} * {32'b0, b_q[63:32]};

    // The total is at most (2^64-1)^2, so this 128-bit sum cannot overflow.
    x_d = {64'b0, p_ll_q}
        + ({64'b0, p_lh_q} << 32)
        + ({64'b0, p_hl_q} << 32)
        + {p_hh_q, 64'b0};

    // out_data keeps the last valid product across bubbles.
    out_d = vld_q[LATENCY-2] ? red : out_q;
  end

  // NOTE: sequential state uses non-blocking (<=) assignments. Every register
  // then samples its old inputs at the edge, whatever the statement order.
  // NOTE: the data registers are reset along with the control bits. They are
  // plain flops, not a memory array, and resetting them makes out_data read 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      last_q <= '0;
      a_q    <= '0;
      b_q    <= '0;
      p_ll_q <= '0;
      p_lh_q <= '0;
      p_hl_q <= '0;
      p_hh_q <= '0;
      x_q    <= '0;
      out_q  <= '0;
    end else if (en) begin
      vld_q  <= vld_d;
      last_q <= last_d;
      a_q    <= a_d;
      b_q    <= b_d;
      p_ll_q <= p_ll_d;
      p_lh_q <= p_lh_d;
      p_hl_q <= p_hl_d;
      p_hh_q <= p_hh_d;
      x_q    <= x_d;
      out_q  <= out_d;
    end
  end

  assign out_valid = vld_q[LATENCY-1];
  assign out_last  = last_q[LATENCY-1];
  assign out_data  = out_q;

endmodule

// File: tb/tb_horizontal_tf_modmul.sv
// Self-checking bench for horizontal_tf_modmul.
// The stimulus pushes expected products, computed with plain 128-bit modulo
// arithmetic, into a scoreboard queue. A separate monitor pops an entry and
// compares it each time the DUT presents a new output.
module tb_horizontal_tf_modmul;
  import fftc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        CEN;
  logic        in_valid;
  logic [63:0] in_data;
  logic [63:0] tf;
  logic        tf_bypass;
  logic        in_last;
  logic        out_valid;
  logic [63:0] out_data;
  logic        out_last;

  horizontal_tf_modmul #(.P_WIDTH(64), .LATENCY(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .CEN       (CEN),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .tf        (tf),
    .tf_bypass (tf_bypass),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b);
    logic [127:0] prod;
    logic [127:0] rem;
    prod = {64'b0, a} * {64'b0, b};
    rem  = prod % {64'b0, P_GOLD};
    return rem[63:0];
  endfunction

  function automatic logic [63:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return P_GOLD;
      1:       return P_GOLD - 64'd1;
      2:       return 64'hFFFFFFFFFFFFFFFF;
      3:       return 64'd0;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Drive one cycle of inputs on the falling edge. A sample is expected only
  // when the enable is active at the following rising edge.
  task automatic drive(input bit cen, input bit v, input logic [63:0] d,
                       input logic [63:0] t, input bit byp, input bit last);
    exp_t e;
    @(negedge clk);
    CEN = cen; in_valid = v; in_data = d; tf = t; tf_bypass = byp; in_last = last;
    if (!cen && v) begin
      e.data = ref_mul(d, byp ? 64'd1 : t);
      e.last = last;
      sb.push_back(e);
    end
  endtask

  // Issue one sample into an empty pipeline and count enabled edges until
  // out_valid appears. The edge that samples the input counts as the first.
  task automatic lat_test(input string name, input logic [63:0] a, input logic [63:0] t,
                          input bit byp, input logic [63:0] req);
    int n;
    bit seen;
    seen = 1'b0;
    drive(1'b0, 1'b1, a, t, byp, 1'b1);
    @(posedge clk);
    n = 1;
    #1;
    while (n < 12) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      n++;
      #1;
    end
    check({name, "_latency"}, seen ? n : 0, 4);
    check({name, "_data"}, out_data, req);
    check({name, "_last"}, out_last, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Monitor. A new output exists only after an enabled edge. After an edge with
  // CEN=1, all outputs must match what they were one cycle earlier.
  initial begin
    bit          en;
    logic [65:0] prev;
    exp_t        e;
    prev = '0;
    forever begin
      @(posedge clk);
      en = !CEN;
      @(negedge clk);
      if (mon_en && rst_n) begin
        if (en) begin
          if (out_valid) begin
            if (sb.size() == 0) begin
              check("sb_unexpected_output", 1, 0);
            end else begin
              e = sb.pop_front();
              check("sb_data", out_data, e.data);
              check("sb_last", out_last, e.last);
            end
          end
        end else begin
          check("hold_while_cen", {out_valid, out_data, out_last}, prev);
        end
      end
      prev = {out_valid, out_data, out_last};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    rst_n = 1'b0; CEN = 1'b1; in_valid = 1'b0; in_data = '0; tf = '0;
    tf_bypass = 1'b0; in_last = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {out_valid, out_data, out_last}, 66'd0);
    rst_n = 1'b1;
    CEN   = 1'b0;
    mon_en = 1'b1;

    // Directed boundary products.
    lat_test("one_x_one", 64'd1, 64'd1, 1'b0, 64'd1);
    lat_test("pm1_sq", 64'hFFFFFFFF00000000, 64'hFFFFFFFF00000000, 1'b0, 64'd1);
    lat_test("two32_sq", 64'h0000000100000000, 64'h0000000100000000, 1'b0,
             64'h00000000FFFFFFFF);
    lat_test("two48_sq", 64'h0001000000000000, 64'h0001000000000000, 1'b0,
             64'hFFFFFFFF00000000);
    lat_test("noncanon_bypass", 64'hFFFFFFFFFFFFFFFF, 64'hDEADBEEFDEADBEEF, 1'b1,
             64'h00000000FFFFFFFE);

    // Random stream with CEN gaps (inputs dropped) and valid bubbles.
    sent = 0;
    while (sent < 32) begin
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3))
          drive(1'b1, 1'($urandom_range(0, 1)), rand_op(), rand_op(), 1'b0, 1'b1);
      if ($urandom_range(0, 4) == 0)
        drive(1'b0, 1'b0, rand_op(), rand_op(), 1'b0, 1'b1);
      drive(1'b0, 1'b1, rand_op(), rand_op(), ($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 1)));
      sent++;
    end
    repeat (8) drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    check("stream_drained", sb.size(), 0);

    // Reset with three samples in flight.
    repeat (3) drive(1'b0, 1'b1, rand_op(), rand_op(), 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    mon_en   = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", {out_valid, out_data, out_last}, 66'd0);
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 check("no_stale_valid", out_valid, 0);
    end
    @(negedge clk);
    mon_en = 1'b1;
    begin
      logic [63:0] a, b;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      lat_test("post_reset", a, b, 1'b0, ref_mul(a, b));
    end
    repeat (4) drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
    check("final_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
